// File: rtl/z3_pkg.sv
// Shared definitions for the Zorro III bus-master engine.
//   z3_state_t     : engine state encoding
//   FC_SUPER_DATA  : function code driven on every owned cycle
//   SYNC_STAGES    : depth of the synchronisers on asynchronous bus inputs
package z3_pkg;

   typedef enum logic [2:0] {
      IDLE, ARB, ADDR, STRB, DATA, WAIT, TERM, RECOVER
   } z3_state_t;

   localparam logic [2:0] FC_SUPER_DATA = 3'b101;
   localparam int         SYNC_STAGES   = 2;

endpackage

// File: rtl/z3_bus_master_if.sv
// Zorro III bus signals seen by one initiator.
//   master : BR_n, OWN, address/control/strobes and write data out;
//            BG_n, Z_DIN, Z_DTACK_n, Z_BERR_n in
//   slave  : the opposite view (arbiter + target side)
interface z3_bus_master_if;

   logic        BR_n;
   logic        BG_n;
   logic        OWN;
   logic [31:0] Z_ADDR;
   logic [2:0]  Z_FC;
   logic        Z_READ;
   logic        Z_FCS_n;
   logic [3:0]  Z_DS_n;
   logic        Z_DOE;
   logic        Z_DOUT_OE;
   logic [31:0] Z_DOUT;
   logic [31:0] Z_DIN;
   logic        Z_DTACK_n;
   logic        Z_BERR_n;

   modport master (
      output BR_n, OWN, Z_ADDR, Z_FC, Z_READ, Z_FCS_n, Z_DS_n, Z_DOE, Z_DOUT_OE, Z_DOUT,
      input  BG_n, Z_DIN, Z_DTACK_n, Z_BERR_n
   );

   modport slave (
      input  BR_n, OWN, Z_ADDR, Z_FC, Z_READ, Z_FCS_n, Z_DS_n, Z_DOE, Z_DOUT_OE, Z_DOUT,
      output BG_n, Z_DIN, Z_DTACK_n, Z_BERR_n
   );

endinterface

// File: rtl/z3_sync.sv
// N-stage synchroniser for an active-low asynchronous bus input.
//   CLK, IORST_n : block clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronised output; resets to 1 (signal negated)
// STAGES must be at least 2.
module z3_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic IORST_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge CLK or negedge IORST_n) begin
      if (!IORST_n) sr <= '1;
      else          sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/z3_bus_master.sv
// Zorro III bus-master engine: runs one full-cycle transfer per request
// from the local DMA side and returns read data or an error status.
//   CLK, IORST_n      : block clock, async active-low reset
//   req, req_addr, req_we, req_be, req_wdata : request (held until ack/err)
//   req_ack / req_err : one-cycle completion pulses (mutually exclusive)
//   req_rdata         : read data, valid from req_ack until next address phase
//   bus               : Zorro III master view (arbitration, strobes, data)
// All bus-side outputs are registered decodes of the next state, so every
// strobe is glitch-free and changes exactly on a state transition.
module z3_bus_master
   import z3_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit HOLD_BUS       = 1'b1
) (
   input  logic               CLK,
   input  logic               IORST_n,
   input  logic               req,
   input  logic [31:0]        req_addr,
   input  logic               req_we,
   input  logic [3:0]         req_be,
   input  logic [31:0]        req_wdata,
   output logic               req_ack,
   output logic               req_err,
   output logic [31:0]        req_rdata,
   z3_bus_master_if.master    bus
);

   // Counter is at least 8 bits, wider only if the timeout needs it.
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

   z3_state_t   state, state_d;
   logic        bg_s, dtack_s, berr_s;
   logic [CW-1:0] cnt;

   logic        load, strobed, ok_end, err_end;
   logic        we_q;
   logic [3:0]  be_q;
   logic        br_n_q, own_q, read_q, fcs_n_q, doe_q, dout_oe_q;
   logic [3:0]  ds_n_q;
   logic [31:0] addr_q, dout_q;

   // Lane selection comes from req_be; the low address bits are not driven.
   logic        addr_lo_unused;
   assign addr_lo_unused = ^req_addr[1:0];

   z3_sync #(.STAGES(SYNC_STAGES)) u_sync_bg    (.CLK(CLK), .IORST_n(IORST_n), .d(bus.BG_n),      .q(bg_s));
   z3_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (.CLK(CLK), .IORST_n(IORST_n), .d(bus.Z_DTACK_n), .q(dtack_s));
   z3_sync #(.STAGES(SYNC_STAGES)) u_sync_berr  (.CLK(CLK), .IORST_n(IORST_n), .d(bus.Z_BERR_n),  .q(berr_s));

   always_ff @(posedge CLK or negedge IORST_n) begin
      if (!IORST_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      strobed = 1'b0;
      ok_end  = 1'b0;
      err_end = 1'b0;
      unique case (state)
         IDLE:    if (req) state_d = own_q ? ADDR : ARB;
         // Wait for the previous owner's slave to release DTACK before taking the bus.
         ARB:     if (!bg_s && dtack_s) state_d = ADDR;
         ADDR:    state_d = STRB;
         STRB:    state_d = DATA;
         DATA:    state_d = WAIT;
         WAIT: begin
            // BERR has priority over a coincident DTACK.
            if (!berr_s) begin
               state_d = TERM;
               err_end = 1'b1;
            end else if (!dtack_s) begin
               state_d = TERM;
               ok_end  = 1'b1;
            end else if (cnt == TMO) begin
               state_d = TERM;
               err_end = 1'b1;
            end
         end
         TERM:    state_d = RECOVER;
         RECOVER: if (dtack_s) state_d = (HOLD_BUS && req) ? ADDR : IDLE;
         default: state_d = IDLE;
      endcase
      load    = (state_d == ADDR);
      strobed = (state_d == DATA) || (state_d == WAIT);
   end

   always_ff @(posedge CLK or negedge IORST_n) begin
      if (!IORST_n) begin
         br_n_q    <= 1'b1;
         own_q     <= 1'b0;
         read_q    <= 1'b1;
         fcs_n_q   <= 1'b1;
         ds_n_q    <= 4'hF;
         doe_q     <= 1'b0;
         dout_oe_q <= 1'b0;
         addr_q    <= '0;
         dout_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= 4'hF;
         cnt       <= '0;
         req_ack   <= 1'b0;
         req_err   <= 1'b0;
         req_rdata <= '0;
      end else begin
         br_n_q    <= (state_d != ARB);
         own_q     <= (state_d != IDLE) && (state_d != ARB);
         fcs_n_q   <= !((state_d == STRB) || strobed);
         ds_n_q    <= strobed ? ~be_q : 4'hF;
         doe_q     <= strobed;
         dout_oe_q <= strobed && we_q;
         req_ack   <= ok_end;
         req_err   <= err_end;
         if (load) begin
            addr_q <= {req_addr[31:2], 2'b00};
            read_q <= !req_we;
            we_q   <= req_we;
            be_q   <= req_be;
            dout_q <= req_wdata;
         end
         if (state_d == DATA)                  cnt <= '0;
         else if (state == WAIT && cnt != '1)  cnt <= cnt + 1'b1;
         if (ok_end && !we_q) req_rdata <= bus.Z_DIN;
      end
   end

   assign bus.BR_n      = br_n_q;
   assign bus.OWN       = own_q;
   assign bus.Z_ADDR    = addr_q;
   assign bus.Z_FC      = FC_SUPER_DATA;
   assign bus.Z_READ    = read_q;
   assign bus.Z_FCS_n   = fcs_n_q;
   assign bus.Z_DS_n    = ds_n_q;
   assign bus.Z_DOE     = doe_q;
   assign bus.Z_DOUT_OE = dout_oe_q;
   assign bus.Z_DOUT    = dout_q;

endmodule

// File: tb/tb_z3_bus_master.sv
// Bench for z3_bus_master: directed scenarios followed by random transfers,
// with a behavioural arbiter/slave and a transaction-level expectation model.
module tb_z3_bus_master;

   localparam int TMO = 16;

   logic        CLK = 1'b0;
   logic        IORST_n = 1'b1;
   logic        req = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_we = 1'b0;
   logic [3:0]  req_be = 4'hF;
   logic [31:0] req_wdata = '0;
   logic        req_ack, req_err;
   logic [31:0] req_rdata;

   z3_bus_master_if bus();

   z3_bus_master #(.TIMEOUT_CYCLES(TMO), .HOLD_BUS(1'b1)) dut (
      .CLK(CLK), .IORST_n(IORST_n), .req(req), .req_addr(req_addr), .req_we(req_we),
      .req_be(req_be), .req_wdata(req_wdata), .req_ack(req_ack), .req_err(req_err),
      .req_rdata(req_rdata), .bus(bus)
   );

   always #5 CLK = ~CLK;

   int vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // slave / arbiter behaviour for the current transfer
   int          s_gnt_dly = 0, s_dtk_dly = 0, s_mode = 0;   // mode 0 ok,1 berr,2 berr+dtack,3 silent
   logic [31:0] s_din = '0;
   int          gcnt = 0, dcnt = 0;

   // monitor observations
   int          br_falls = 0, own_drops = 0, strobes = 0, ack_tot = 0, err_tot = 0, viol = 0, ds_cyc = 0;
   logic [3:0]  obs_ds = 4'hF, ds_prev = 4'hF;
   logic [31:0] obs_addr = '0, obs_dout = '0;
   logic        obs_read = 1'b1, obs_oe_seen = 1'b0;
   logic        br_prev = 1'b1, own_prev = 1'b0, ack_prev = 1'b0, err_prev = 1'b0;

   always @(negedge CLK) begin
      if (bus.BR_n === 1'b0 && br_prev === 1'b1) br_falls++;
      if (bus.OWN === 1'b0 && own_prev === 1'b1) own_drops++;
      if (req_ack === 1'b1) begin ack_tot++; if (ack_prev === 1'b1) viol++; end
      if (req_err === 1'b1) begin err_tot++; if (err_prev === 1'b1) viol++; end
      if (req_ack === 1'b1 && req_err === 1'b1) viol++;
      if (bus.Z_FCS_n !== 1'b0 && (bus.Z_DS_n !== 4'hF || bus.Z_DOE !== 1'b0 || bus.Z_DOUT_OE !== 1'b0)) viol++;
      if (bus.Z_DS_n !== 4'hF) begin
         if (ds_prev === 4'hF) begin
            strobes++; ds_cyc = 0; obs_oe_seen = 1'b0; obs_addr = bus.Z_ADDR;
         end else if (bus.Z_ADDR !== obs_addr) viol++;
         ds_cyc++;
         obs_ds = bus.Z_DS_n;
         obs_read = bus.Z_READ;
         if (bus.Z_DOUT_OE === 1'b1) begin obs_oe_seen = 1'b1; obs_dout = bus.Z_DOUT; end
      end
      br_prev = bus.BR_n; own_prev = bus.OWN; ack_prev = req_ack; err_prev = req_err; ds_prev = bus.Z_DS_n;
      // arbiter
      if (bus.BR_n === 1'b0) begin gcnt++; bus.BG_n = (gcnt > s_gnt_dly) ? 1'b0 : 1'b1; end
      else begin gcnt = 0; bus.BG_n = 1'b1; end
      // target
      if (bus.Z_FCS_n === 1'b0 && bus.Z_DS_n !== 4'hF) begin
         dcnt++;
         if (dcnt > s_dtk_dly) begin
            bus.Z_DIN     = s_din;
            bus.Z_DTACK_n = !(s_mode == 0 || s_mode == 2);
            bus.Z_BERR_n  = !(s_mode == 1 || s_mode == 2);
         end
      end else if (bus.Z_FCS_n !== 1'b0) begin
         dcnt = 0; bus.Z_DTACK_n = 1'b1; bus.Z_BERR_n = 1'b1;
      end
   end

   // transaction-level expectations
   logic        e_ack, e_we, e_b2b, e_tmo, e_read;
   logic [3:0]  e_ds;
   logic [31:0] e_addr, e_wd, e_din, exp_rdata = '0;
   int          exp_ack_tot = 0, exp_err_tot = 0, snap_br = 0, snap_own = 0, snap_str = 0;

   task automatic present(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] din, input int gd, input int dd, input int mode, input bit b2b);
      s_gnt_dly = gd; s_dtk_dly = dd; s_mode = mode; s_din = din;
      req_addr = a; req_we = we; req_be = be; req_wdata = wd; req = 1'b1;
      e_ack = (mode == 0); e_addr = {a[31:2], 2'b00}; e_ds = ~be; e_read = ~we; e_we = we;
      e_wd = wd; e_din = din; e_b2b = b2b; e_tmo = (mode == 3);
      snap_br = br_falls; snap_own = own_drops; snap_str = strobes;
   endtask

   task automatic finish(input bit next_b2b);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge CLK); #2;
         if (req_ack === 1'b1 || req_err === 1'b1) done = 1'b1;
      end
      chk("complete", done, 1);
      if (e_ack && !e_we) exp_rdata = e_din;
      if (e_ack) exp_ack_tot++; else exp_err_tot++;
      chk("ack", req_ack, e_ack);
      chk("err", req_err, !e_ack);
      chk("rdata", req_rdata, exp_rdata);
      chk("strobe_cnt", strobes - snap_str, 1);
      chk("ds", obs_ds, e_ds);
      chk("addr", obs_addr, e_addr);
      chk("read", obs_read, e_read);
      chk("dout_oe", obs_oe_seen, e_we);
      if (e_we) chk("dout", obs_dout, e_wd);
      chk("br_req", br_falls - snap_br, e_b2b ? 0 : 1);
      if (e_b2b) chk("own_cont", own_drops - snap_own, 0);
      chk("fcs_rel", bus.Z_FCS_n, 1);
      chk("ds_rel", bus.Z_DS_n, 4'hF);
      if (e_tmo) chk("tmo_lat", (ds_cyc >= TMO && ds_cyc <= TMO + 3), 1);
      if (!next_b2b) begin
         req = 1'b0;
         repeat (6) @(posedge CLK);
         #2;
         chk("own_idle", bus.OWN, 0);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_br"}, bus.BR_n, 1);
      chk({p, "_own"}, bus.OWN, 0);
      chk({p, "_fcs"}, bus.Z_FCS_n, 1);
      chk({p, "_ds"}, bus.Z_DS_n, 4'hF);
      chk({p, "_doe"}, bus.Z_DOE, 0);
      chk({p, "_dout_oe"}, bus.Z_DOUT_OE, 0);
      chk({p, "_read"}, bus.Z_READ, 1);
      chk({p, "_ack"}, req_ack, 0);
      chk({p, "_err"}, req_err, 0);
      chk({p, "_rdata"}, req_rdata, 0);
      chk({p, "_addr"}, bus.Z_ADDR, 0);
      chk({p, "_fc"}, bus.Z_FC, 3'b101);
   endtask

   initial begin
      int sa, se, mode;
      bit nb, cb;
      logic [31:0] ra;
      #1 IORST_n = 1'b0;
      repeat (3) @(posedge CLK);
      #2 chk_reset("reset");
      IORST_n = 1'b1;
      repeat (2) @(posedge CLK);
      #2;

      // read, grant after 3, DTACK after 2
      present(32'h4000_0010, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 3, 2, 0, 1'b0);
      finish(1'b0);
      // single upper-lane write
      present(32'h4000_0020, 1'b1, 4'b1000, 32'h5A00_0000, 32'h0, 1, 1, 0, 1'b0);
      finish(1'b0);
      // silent slave -> timeout
      present(32'h4000_0030, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 0, 0, 3, 1'b0);
      finish(1'b0);
      // BERR and DTACK together -> error, read data kept
      present(32'h4000_0040, 1'b0, 4'b0011, 32'h0, 32'h2222_2222, 0, 1, 2, 1'b0);
      finish(1'b0);
      // two back-to-back reads under one ownership
      present(32'h4000_0050, 1'b0, 4'hF, 32'h0, 32'h3333_3333, 2, 0, 0, 1'b0);
      finish(1'b1);
      present(32'h4000_0054, 1'b0, 4'hF, 32'h0, 32'h4444_4444, 2, 0, 0, 1'b1);
      finish(1'b0);

      // reset in the middle of a waiting cycle
      present(32'h1234_5678, 1'b0, 4'hF, 32'h0, 32'h0, 0, 0, 3, 1'b0);
      for (int i = 0; i < 50 && bus.Z_DS_n === 4'hF; i++) begin @(posedge CLK); #2; end
      chk("rst_reach_wait", bus.Z_DS_n !== 4'hF, 1);
      sa = ack_tot; se = err_tot;
      @(posedge CLK);
      #3 IORST_n = 1'b0;
      #1 chk_reset("rst_wait");
      req = 1'b0;
      exp_rdata = '0;
      repeat (3) @(posedge CLK);
      #2 IORST_n = 1'b1;
      repeat (5) @(posedge CLK);
      #2;
      chk("rst_no_pulse", (ack_tot - sa) + (err_tot - se), 0);
      chk("rst_own", bus.OWN, 0);

      // random transfers
      cb = 1'b0;
      for (int n = 0; n < 30; n++) begin
         mode = $urandom_range(0, 9);
         if (mode > 3) mode = 0;
         ra = $urandom;
         present(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 5), mode, cb);
         nb = (n < 29) && ($urandom_range(0, 2) == 0);
         finish(nb);
         cb = nb;
      end

      repeat (4) @(posedge CLK);
      #2;
      chk("ack_total", ack_tot, exp_ack_tot);
      chk("err_total", err_tot, exp_err_tot);
      chk("protocol", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
